glb_bank_sram_arb: RTL
======================

GLB_BANK_SRAM_ARB -- requirements
Module: glb_bank_sram_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning SRAM word width; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning word address width of the bank SRAM.
REQ-003 SHALL have port CLK, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-005 SHALL have ports pN_req_valid (input, 1) and pN_req_ready (output, 1), N=0,1, meaning requester handshake.
REQ-006 SHALL have ports pN_wr_en (input, 1), pN_addr (input, ADDR_WIDTH), pN_wr_data (input, DATA_WIDTH) and pN_wr_strb (input, DATA_WIDTH/8), meaning the request payload; wr_strb is active-high per byte.
REQ-007 SHALL have ports pN_rd_data_valid (output, 1) and pN_rd_data (output, DATA_WIDTH), meaning the read response.
REQ-008 SHALL have SRAM-side outputs sram_CEB (1), sram_WEB (1), sram_A (ADDR_WIDTH), sram_D (DATA_WIDTH) and sram_BWEB (DATA_WIDTH), all active-low per the macro convention, plus input sram_Q (DATA_WIDTH).
REQ-009 SHALL have output conflict_cnt, 16 bits, meaning the number of cycles in which both requesters were valid.

Function
REQ-010 SHALL drive the SRAM-side outputs and the ready signals combinationally from the current requests and arbiter state.
REQ-011 SHALL grant at most one requester per cycle; a transfer occurs when valid and ready are both high on the same edge.
REQ-012 SHALL give the grant to the only valid requester when just one is valid, regardless of arbiter state.
REQ-013 SHALL arbitrate round-robin when both are valid: the grant goes to the port not granted last; last_grant updates only on a transfer.
REQ-014 SHALL, when no requester is valid, drive sram_CEB=1, sram_WEB=1, sram_BWEB all ones, and sram_A/sram_D to zero.
REQ-015 SHALL drive, for a granted request, sram_CEB=0, sram_WEB=~wr_en, sram_A=addr and sram_D=wr_data.
REQ-016 SHALL drive sram_BWEB byte b as {8{~wr_strb[b]}} for a write, and all ones for a read.
REQ-017 SHALL track each read transfer in a 2-stage {valid, port} shift pipeline, because the SRAM read latency is 2 cycles (request at edge n, sram_Q valid after edge n+2).
REQ-018 SHALL assert pN_rd_data_valid=1 for exactly one cycle, with pN_rd_data=sram_Q, in the cycle in which the pipeline tail holds valid with port N.
REQ-019 SHALL drive pN_rd_data to zero while pN_rd_data_valid is 0.
REQ-020 SHALL return read responses in issue order, and only to the issuing port.
REQ-021 SHALL sustain back-to-back reads, one per cycle, with no bubbles.
REQ-022 SHALL apply same-address traffic in grant order with no hazard logic: a write at n followed by a read at n+1 returns the new data.
REQ-023 SHALL increment conflict_cnt by 1 in each cycle with p0_req_valid and p1_req_valid both high, saturating at 16'hFFFF.

Reset
REQ-024 SHALL, when reset is high at a clock edge, clear last_grant to 1 (so port 0 wins the first conflict), clear the read-tracking pipeline, and clear conflict_cnt to 0.
REQ-025 SHALL discard reads in flight when reset is asserted mid-operation: no rd_data_valid is produced for them after reset.
REQ-026 SHALL hold pN_req_ready=0 and sram_CEB=1 while reset is high.
REQ-027 SHALL hold all rd_data_valid outputs at 0 during reset and in the first cycle after it.

Configuration
REQ-028 SHALL, when GLB_BANK_SRAM_ARB_RD_REG_EN is defined, register rd_data_valid and rd_data, giving a read latency of 3 cycles; the register resets to valid=0, data=0.
REQ-029 SHALL, when GLB_BANK_SRAM_ARB_RD_REG_EN is not defined, drive the read response combinationally with a read latency of 2 cycles; the arbitration behaviour is identical in both builds.

Verification
REQ-030 SHALL cover: p0 writes 0xDEADBEEF_01234567 to 0x0005 with strb 0xFF, then reads 0x0005 -> p0_rd_data_valid 2 cycles later (3 with the macro), data matches, p1 sees no valid.
REQ-031 SHALL cover: both ports request reads continuously for 6 cycles -> grants alternate p0,p1,p0,...; conflict_cnt=6; every response is routed to the correct port.
REQ-032 SHALL cover: p1 writes 0xFFFF... then writes 0x0 with strb 0x0F to the same address, then reads -> 0xFFFFFFFF_00000000.
REQ-033 SHALL cover: reset asserted one cycle after a p0 read grant -> no p0_rd_data_valid afterwards; conflict_cnt=0; the first conflict after reset is granted to p0.
REQ-034 SHALL cover: conflict_cnt preloaded near saturation via a long dual-valid run -> holds at 0xFFFF.
REQ-035 SHALL cover: p1 only valid while last_grant=1 -> p1 granted immediately, with no idle cycle.

Source files
------------

// File: rtl/glb_bank_sram_arb_if.sv
// Requester, read-response and SRAM-macro signals of the two-port GLB bank arbiter.
// The slave modport is the arbiter side; the master modport is the requester/SRAM side.
interface glb_bank_sram_arb_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 14
);
   logic                      p0_req_valid;
   logic                      p0_req_ready;
   logic                      p0_wr_en;
   logic [ADDR_WIDTH-1:0]     p0_addr;
   logic [DATA_WIDTH-1:0]     p0_wr_data;
   logic [DATA_WIDTH/8-1:0]   p0_wr_strb;
   logic                      p0_rd_data_valid;
   logic [DATA_WIDTH-1:0]     p0_rd_data;

   logic                      p1_req_valid;
   logic                      p1_req_ready;
   logic                      p1_wr_en;
   logic [ADDR_WIDTH-1:0]     p1_addr;
   logic [DATA_WIDTH-1:0]     p1_wr_data;
   logic [DATA_WIDTH/8-1:0]   p1_wr_strb;
   logic                      p1_rd_data_valid;
   logic [DATA_WIDTH-1:0]     p1_rd_data;

   logic                      sram_CEB;
   logic                      sram_WEB;
   logic [ADDR_WIDTH-1:0]     sram_A;
   logic [DATA_WIDTH-1:0]     sram_D;
   logic [DATA_WIDTH-1:0]     sram_BWEB;
   logic [DATA_WIDTH-1:0]     sram_Q;

   logic [15:0]               conflict_cnt;

   modport slave (
      input  p0_req_valid, p0_wr_en, p0_addr, p0_wr_data, p0_wr_strb,
      input  p1_req_valid, p1_wr_en, p1_addr, p1_wr_data, p1_wr_strb,
      input  sram_Q,
      output p0_req_ready, p0_rd_data_valid, p0_rd_data,
      output p1_req_ready, p1_rd_data_valid, p1_rd_data,
      output sram_CEB, sram_WEB, sram_A, sram_D, sram_BWEB,
      output conflict_cnt
   );

   modport master (
      output p0_req_valid, p0_wr_en, p0_addr, p0_wr_data, p0_wr_strb,
      output p1_req_valid, p1_wr_en, p1_addr, p1_wr_data, p1_wr_strb,
      output sram_Q,
      input  p0_req_ready, p0_rd_data_valid, p0_rd_data,
      input  p1_req_ready, p1_rd_data_valid, p1_rd_data,
      input  sram_CEB, sram_WEB, sram_A, sram_D, sram_BWEB,
      input  conflict_cnt
   );
endinterface

// File: rtl/glb_bank_sram_arb.sv
// Two-port round-robin arbiter in front of a 2-cycle-latency bank SRAM macro.
// Define GLB_BANK_SRAM_ARB_RD_REG_EN to register the read response (latency 3 instead of 2).
module glb_bank_sram_arb #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                 CLK,
   input  logic                 reset,
   glb_bank_sram_arb_if.slave   bus
);
   localparam int STRB_W = DATA_WIDTH / 8;

   logic        last_grant;
   logic        gnt0;
   logic        gnt1;
   logic        rd_issue;
   logic        vld_p1;
   logic        port_p1;
   logic        vld_p2;
   logic        port_p2;
   logic        rsp0_vld;
   logic        rsp1_vld;
   logic [15:0] conflict_cnt_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] strb_to_bweb(input logic [STRB_W-1:0] s);
      logic [DATA_WIDTH-1:0] m;
      for (int b = 0; b < STRB_W; b++) m[b*8 +: 8] = {8{~s[b]}};
      return m;
   endfunction

   // A lone requester always wins; on a conflict the port not granted last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (bus.p0_req_valid && (!bus.p1_req_valid || last_grant)) gnt0 = 1'b1;
         else if (bus.p1_req_valid)                                  gnt1 = 1'b1;
      end
   end

   assign bus.p0_req_ready = gnt0;
   assign bus.p1_req_ready = gnt1;
   assign rd_issue         = (gnt0 & ~bus.p0_wr_en) | (gnt1 & ~bus.p1_wr_en);

   always_comb begin
      bus.sram_CEB  = 1'b1;
      bus.sram_WEB  = 1'b1;
      bus.sram_A    = '0;
      bus.sram_D    = '0;
      bus.sram_BWEB = '1;
      if (gnt0) begin
         bus.sram_CEB  = 1'b0;
         bus.sram_WEB  = ~bus.p0_wr_en;
         bus.sram_A    = bus.p0_addr;
         bus.sram_D    = bus.p0_wr_data;
         bus.sram_BWEB = bus.p0_wr_en ? strb_to_bweb(bus.p0_wr_strb) : '1;
      end else if (gnt1) begin
         bus.sram_CEB  = 1'b0;
         bus.sram_WEB  = ~bus.p1_wr_en;
         bus.sram_A    = bus.p1_addr;
         bus.sram_D    = bus.p1_wr_data;
         bus.sram_BWEB = bus.p1_wr_en ? strb_to_bweb(bus.p1_wr_strb) : '1;
      end
   end

   // p1/p2: read-tracking stages matching the SRAM read latency
   always_ff @(posedge CLK) begin
      if (reset) begin
         last_grant     <= 1'b1;
         vld_p1         <= 1'b0;
         vld_p2         <= 1'b0;
         conflict_cnt_q <= 16'd0;
      end else begin
         if (gnt0)      last_grant <= 1'b0;
         else if (gnt1) last_grant <= 1'b1;
         vld_p1 <= rd_issue;
         vld_p2 <= vld_p1;
         if (bus.p0_req_valid && bus.p1_req_valid) conflict_cnt_q <= sat_inc16(conflict_cnt_q);
      end
   end

   always_ff @(posedge CLK) begin
      port_p1 <= gnt1;
      port_p2 <= port_p1;
   end

   assign bus.conflict_cnt = conflict_cnt_q;
   assign rsp0_vld = vld_p2 & ~port_p2 & ~reset;
   assign rsp1_vld = vld_p2 &  port_p2 & ~reset;

`ifdef GLB_BANK_SRAM_ARB_RD_REG_EN
   logic                  vld0_p3;
   logic                  vld1_p3;
   logic [DATA_WIDTH-1:0] data0_p3;
   logic [DATA_WIDTH-1:0] data1_p3;

   // p3: registered response stage
   always_ff @(posedge CLK) begin
      if (reset) begin
         vld0_p3  <= 1'b0;
         vld1_p3  <= 1'b0;
         data0_p3 <= '0;
         data1_p3 <= '0;
      end else begin
         vld0_p3  <= rsp0_vld;
         vld1_p3  <= rsp1_vld;
         data0_p3 <= rsp0_vld ? bus.sram_Q : '0;
         data1_p3 <= rsp1_vld ? bus.sram_Q : '0;
      end
   end

   assign bus.p0_rd_data_valid = vld0_p3 & ~reset;
   assign bus.p1_rd_data_valid = vld1_p3 & ~reset;
   assign bus.p0_rd_data       = (vld0_p3 & ~reset) ? data0_p3 : '0;
   assign bus.p1_rd_data       = (vld1_p3 & ~reset) ? data1_p3 : '0;
`else
   assign bus.p0_rd_data_valid = rsp0_vld;
   assign bus.p1_rd_data_valid = rsp1_vld;
   assign bus.p0_rd_data       = rsp0_vld ? bus.sram_Q : '0;
   assign bus.p1_rd_data       = rsp1_vld ? bus.sram_Q : '0;
`endif
endmodule
